mem_bus_arbiter: RTL

//  Sits between the core's fetch/mem-access ports and the single-ported memory bus.

---
 rtl/mem_bus_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - fetch/data arbiter onto a single-outstanding memory bus
module mem_bus_arbiter #(
  parameter int XLEN           = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              imem_req,
  input  logic [31:0]       imem_addr,
  output logic              imem_ready,
  output logic              imem_valid,
  output logic              imem_err,
  output logic [XLEN-1:0]   imem_data,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_read_req,
  input  logic              mem_write_req,
  input  logic [2:0]        mem_size,
  input  logic              mem_signed,
  output logic [XLEN-1:0]   mem_rdata,
  output logic              mem_ready,
  output logic              mem_error,
  output logic              bus_req,
  output logic              bus_we,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [XLEN/8-1:0] bus_be,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [XLEN-1:0]   bus_rdata,
  input  logic              bus_err
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
    $fatal(1, "mem_bus_arbiter: XLEN must be 32 or 64");
  end

  typedef enum logic [1:0] {IDLE, ADDR, RESP, DONE} state_t;

  state_t          state;
  logic [TW-1:0]   tcnt;
  logic            last_dmem;
  logic            cur_fetch;
  logic [OFFW-1:0] cur_off;
  logic [1:0]      cur_size;
  logic            cur_signed;

  logic            dmem_pend, sel_dmem, sel_any, sel_bad, timeout;
  logic            fin, fin_err, fin_fetch;
  logic [XLEN-1:0] sel_addr, shifted, low_mask, load_data, fetch_data;
  logic [OFFW-1:0] sel_off;
  logic [7:0]      lane;
  logic [NB-1:0]   sel_be;
  logic            sbit;

  // dmem wins unless both are pending and it also took the previous grant
  assign dmem_pend = mem_read_req | mem_write_req;
  assign sel_dmem  = dmem_pend & (~imem_req | ~last_dmem);
  assign sel_any   = dmem_pend | imem_req;
  assign sel_addr  = sel_dmem ? mem_addr : XLEN'(imem_addr);
  assign sel_off   = sel_addr[OFFW-1:0];
  assign timeout   = (tcnt >= TW'(TIMEOUT_CYCLES - 1));
  assign imem_ready = (state == IDLE) && !dmem_pend;

  always_comb begin
    sel_bad = 1'b0;
    if (sel_dmem) begin
      if (mem_size > 3'd3 || (mem_size == 3'd3 && XLEN == 32))
        sel_bad = 1'b1;
      else
        sel_bad = (mem_addr[2:0] & ((3'b001 << mem_size[1:0]) - 3'b001)) != 3'b000;
    end else begin
      sel_bad = imem_addr[1:0] != 2'b00;
    end
    case (mem_size[1:0])
      2'd0:    lane = 8'h01;
      2'd1:    lane = 8'h03;
      2'd2:    lane = 8'h0F;
      default: lane = 8'hFF;
    endcase
    sel_be = sel_dmem ? (NB'(lane) << sel_off) : '1;
  end

  // Fetch data reuses the load shifter: an aligned fetch offset selects the word
  always_comb begin
    shifted  = bus_rdata >> {cur_off, 3'b000};
    low_mask = '1;
    sbit     = 1'b0;
    case (cur_size)
      2'd0:    begin low_mask = XLEN'(8'hFF);         sbit = shifted[7];  end
      2'd1:    begin low_mask = XLEN'(16'hFFFF);      sbit = shifted[15]; end
      2'd2:    begin low_mask = XLEN'(32'hFFFF_FFFF); sbit = shifted[31]; end
      default: ;
    endcase
    load_data  = (shifted & low_mask) | ((cur_signed & sbit) ? ~low_mask : '0);
    fetch_data = XLEN'(shifted[31:0]);
  end

  always_comb begin
    fin     = 1'b0;
    fin_err = 1'b1;
    case (state)
      IDLE:    fin = sel_any & sel_bad;
      ADDR:    fin = ~bus_gnt & timeout;
      RESP:    begin fin = bus_rvalid | timeout; fin_err = ~bus_rvalid | bus_err; end
      default: ;
    endcase
    fin_fetch = (state == IDLE) ? ~sel_dmem : cur_fetch;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      tcnt       <= '0;
      last_dmem  <= 1'b0;
      cur_fetch  <= 1'b0;
      cur_off    <= '0;
      cur_size   <= '0;
      cur_signed <= 1'b0;
      imem_valid <= 1'b0;
      imem_err   <= 1'b0;
      imem_data  <= '0;
      mem_rdata  <= '0;
      mem_ready  <= 1'b0;
      mem_error  <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_be     <= '0;
    end else begin
      if (fin) begin
        state      <= DONE;
        bus_req    <= 1'b0;
        imem_valid <= fin_fetch & ~fin_err;
        imem_err   <= fin_fetch & fin_err;
        mem_ready  <= ~fin_fetch;
        mem_error  <= ~fin_fetch & fin_err;
        imem_data  <= (fin_fetch & ~fin_err) ? fetch_data : '0;
        mem_rdata  <= (~fin_fetch & ~fin_err & ~bus_we) ? load_data : '0;
      end
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (sel_any) begin
            last_dmem  <= sel_dmem;
            cur_fetch  <= ~sel_dmem;
            cur_off    <= sel_off;
            cur_size   <= sel_dmem ? mem_size[1:0] : 2'd2;
            cur_signed <= sel_dmem & mem_signed;
            bus_we     <= sel_dmem & mem_write_req;
            bus_addr   <= {sel_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
            bus_be     <= sel_be;
            bus_wdata  <= sel_dmem ? (mem_wdata << {sel_off, 3'b000}) : '0;
            if (!sel_bad) begin
              state   <= ADDR;
              bus_req <= 1'b1;
            end
          end
        end
        ADDR: begin
          tcnt <= tcnt + TW'(1);
          if (bus_gnt) begin
            state   <= RESP;
            bus_req <= 1'b0;
          end
        end
        RESP: tcnt <= tcnt + TW'(1);
        DONE: begin
          state      <= IDLE;
          imem_valid <= 1'b0;
          imem_err   <= 1'b0;
          mem_ready  <= 1'b0;
          mem_error  <= 1'b0;
          imem_data  <= '0;
          mem_rdata  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
